sharpen_window_gen: RTL
=======================

# sharpen_window_gen

Streaming 3x3 window generator that feeds the sharpen core. Accepts one 8-bit grayscale pixel per cycle in raster order over a valid/ready handshake. Buffers the two previous image lines and emits a complete 3x3 neighbourhood (p0..p8) for every interior pixel of the frame. The output is presented on a single registered valid/ready stage.

## Interface
- IMG_W, 640, pixels per line; must be ≥ 3.
- IMG_H, 480, lines per frame; must be ≥ 3.
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_data  in  8  input pixel, raster order, row-major.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a pixel this cycle.
- p0..p8  out  8 each  window, row-major: p0 top-left, p1 top, p2 top-right, p3 left, p4 centre, p5 right, p6 bottom-left, p7 bottom, p8 bottom-right.
- win_valid  out  1  p0..p8 hold a valid window.
- win_ready  in  1  downstream accepts the window this cycle.
- win_last  out  1  qualifies the final window of the frame (valid only with win_valid).

## Operation
- Accept condition: in_valid && in_ready. in_ready = !win_valid || win_ready (combinational). Nothing advances without an accept.
- Counters:
  - col counts 0..IMG_W-1, width $clog2(IMG_W).
  - row counts 0..IMG_H-1, width $clog2(IMG_H).
  - On accept, col increments. At IMG_W-1, col wraps to 0 and row increments.
  - At (IMG_H-1, IMG_W-1), both wrap to 0, so the next accept starts a new frame.
- Line buffers: two arrays of IMG_W x 8 bits, lb1 (row-2) and lb0 (row-1), indexed by col. They are not reset.
  - On accept at col c: top = lb1[c], mid = lb0[c], bot = in_data.
  - Then lb1[c] ← lb0[c] and lb0[c] ← in_data.
- Column shift registers: two 3-pixel columns, L (col c-2) and M (col c-1). On accept, L ← M and M ← {top, mid, bot}.
- Window emit: on an accept at (row, col) with row ≥ 2 and col ≥ 2, load the output registers:
  - p0,p3,p6 from L.
  - p1,p4,p7 from M.
  - p2,p5,p8 from {top, mid, bot}.
  - Set win_valid.
  - The centre pixel is (row-1, col-1).
- Output size: (IMG_W-2) x (IMG_H-2) windows per frame. No border padding.
- Accepts at row < 2 or col < 2 only update state. They do not raise win_valid.
- win_last is set with the window produced by the accept at (IMG_H-1, IMG_W-1). It is cleared with win_valid.
- Output stage:
  - When win_valid && win_ready and no new window is loaded the same cycle, win_valid ← 0.
  - When a handshake and a new load coincide, the new window replaces the old one and win_valid stays 1.
- Column registers carry across line wraps. The row/col guard alone suppresses the stale columns at col 0 and col 1.

## Timing
- Reset (rst_n low at a clk edge):
  - win_valid = 0, win_last = 0, p0..p8 = 0.
  - col = 0, row = 0, L = M = 0.
  - in_ready = 1 in the first cycle after reset.
- Reset mid-frame discards the partial frame. The next accepted pixel is treated as (0,0).
- Latency: the window appears on p0..p8 with win_valid = 1 in the cycle after the accept of its bottom-right pixel.
- Throughput:
  - One pixel per cycle while win_ready stays high.
  - One window per cycle in steady state, except at col 0 and col 1 of each line.
  - No bubbles are inserted at line or frame wrap.
- Backpressure: while win_valid && !win_ready:
  - in_ready = 0.
  - p0..p8, win_valid and win_last hold stable.
  - Counters and buffers hold.
- in_valid may drop at any cycle. The state simply holds.
- in_data is ignored when not accepted.

## Test plan
- Pixel pattern: IMG_W=5, IMG_H=4, pixel = row*16+col, in_valid and win_ready held high.
  - Exactly 6 windows are produced.
  - First window follows the accept of pixel 34: p0..p8 = 0,1,2,16,17,18,32,33,34.
  - Last window: p4 = 35 (p0=18, p8=52), with win_last = 1 on that window only.
- Backpressure: same frame, win_ready low for 3 cycles while the first window is valid.
  - in_ready = 0 for those 3 cycles, window held at the same values.
  - Order and values of all 6 windows unchanged.
- Input bubbles: in_valid toggles 1,0,1,0,… for the whole frame.
  - Same 6 windows, same values.
  - Each window arrives 1 cycle after its completing accept.
- Back-to-back frames: two frames sent with no gap, second frame pixel = 200+row*16+col.
  - Second frame's first window is 200,201,202,216,217,218,232,233,234, with no first-frame data in it.
  - win_last asserts once per frame.
- Reset mid-frame: rst_n low for 1 cycle after 8 pixels are accepted.
  - win_valid = 0 and outputs = 0 after reset.
  - A fresh full frame then yields the same 6 windows as the first scenario.
- Parameter sweep: IMG_W=3, IMG_H=3, pixels 1..9.
  - A single window 1..9 with win_last = 1.
  - The next frame's first window is correct.

Source files
------------

// File: rtl/sharpen_window_gen.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus two column shift
// registers feed a single registered valid/ready output stage.
module sharpen_window_gen #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] p0,
    output logic [7:0] p1,
    output logic [7:0] p2,
    output logic [7:0] p3,
    output logic [7:0] p4,
    output logic [7:0] p5,
    output logic [7:0] p6,
    output logic [7:0] p7,
    output logic [7:0] p8,
    output logic       win_valid,
    input  logic       win_ready,
    output logic       win_last
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

    typedef struct packed {
        logic [7:0] top;
        logic [7:0] mid;
        logic [7:0] bot;
    } pcol_t;

    logic [CW-1:0]   col;
    logic [RW-1:0]   row;
    logic [7:0]      lb0 [IMG_W];
    logic [7:0]      lb1 [IMG_W];
    pcol_t           cur, col_l, col_m;
    logic [8:0][7:0] win;
    logic            accept, emit, at_eol, at_eof;

    assign in_ready = !win_valid || win_ready;
    assign accept   = in_valid && in_ready;
    assign cur      = {lb1[col], lb0[col], in_data};
    assign at_eol   = (col == COL_MAX);
    assign at_eof   = at_eol && (row == ROW_MAX);
    // Stale columns carried over a line wrap are masked by the col >= 2 guard.
    assign emit     = accept && (row >= RW'(2)) && (col >= CW'(2));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (at_eol) begin
                col <= '0;
                row <= at_eof ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Line storage is data-only; the row guard keeps garbage out of windows.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[col] <= lb0[col];
            lb0[col] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_l <= '0;
            col_m <= '0;
        end else if (accept) begin
            col_l <= col_m;
            col_m <= cur;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win       <= '0;
            win_valid <= 1'b0;
            win_last  <= 1'b0;
        end else if (emit) begin
            win       <= {cur.bot, col_m.bot, col_l.bot,
                          cur.mid, col_m.mid, col_l.mid,
                          cur.top, col_m.top, col_l.top};
            win_valid <= 1'b1;
            win_last  <= at_eof;
        end else if (win_valid && win_ready) begin
            win_valid <= 1'b0;
            win_last  <= 1'b0;
        end
    end

    assign p0 = win[0];
    assign p1 = win[1];
    assign p2 = win[2];
    assign p3 = win[3];
    assign p4 = win[4];
    assign p5 = win[5];
    assign p6 = win[6];
    assign p7 = win[7];
    assign p8 = win[8];

endmodule
